// File: rtl/demux_pkg.sv
// +------------------------------------------------------------------+
// | demux_pkg: shared encodings, widths and helpers for demux_2_4     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package demux_pkg;

   localparam int DATA_W     = 32;
   localparam int W0_DEFAULT = 32;
   localparam int W1_DEFAULT = 16;
   localparam int W2_DEFAULT = 32;
   localparam int W3_DEFAULT = 8;

   typedef enum logic [1:0] {
      SEL_CH0 = 2'b00,
      SEL_CH1 = 2'b01,
      SEL_CH2 = 2'b10,
      SEL_CH3 = 2'b11
   } sel_e;

   // True when the word carries set bits that a WIDTH-bit destination would drop.
   function automatic logic above_width(input logic [DATA_W-1:0] word, input int width);
      logic [DATA_W-1:0] upper;
      upper = (width < DATA_W) ? (word >> width) : '0;
      return (upper != '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// +------------------------------------------------------------------+
// | demux_slot: one-entry holding register with valid/ready           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module demux_slot #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             ready,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   logic [WIDTH-1:0] q_d, q_q;
   logic             valid_d, valid_q;

   // A load wins over a drain so a same-cycle drain and refill stays full.
   always_comb begin
      q_d     = q_q;
      valid_d = valid_q;
      if (load) begin
         q_d     = d;
         valid_d = 1'b1;
      end else if (ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         valid_q <= valid_d;
      end
   end

   assign q     = q_q;
   assign valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/demux_2_4.sv
// +------------------------------------------------------------------+
// | demux_2_4: registered 1-to-4 demux with per-channel handshakes    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module demux_2_4
   import demux_pkg::*;
#(
   parameter int W0 = W0_DEFAULT,
   parameter int W1 = W1_DEFAULT,
   parameter int W2 = W2_DEFAULT,
   parameter int W3 = W3_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        select,
   input  logic [DATA_W-1:0] i,
   output logic [W0-1:0]     o0,
   output logic [W1-1:0]     o1,
   output logic [W2-1:0]     o2,
   output logic [W3-1:0]     o3,
   output logic              o0_valid,
   output logic              o1_valid,
   output logic              o2_valid,
   output logic              o3_valid,
   input  logic              o0_ready,
   input  logic              o1_ready,
   input  logic              o2_ready,
   input  logic              o3_ready,
   output logic              trunc_err
);

   logic [3:0] valid_vec;
   logic [3:0] ready_vec;
   logic [3:0] load;
   logic       accept;
   logic       trunc_hit;
   logic       trunc_err_d, trunc_err_q;

   assign valid_vec = {o3_valid, o2_valid, o1_valid, o0_valid};
   assign ready_vec = {o3_ready, o2_ready, o1_ready, o0_ready};

   // Combinational from the selected consumer's ready, deliberately not gated by in_valid.
   assign in_ready = ~valid_vec[select] | ready_vec[select];
   assign accept   = in_valid & in_ready;

   for (genvar k = 0; k < 4; k++) begin : g_decode
      assign load[k] = accept & (select == 2'(k));
   end

   always_comb begin
      trunc_hit = 1'b0;
      case (select)
         SEL_CH0: trunc_hit = above_width(i, W0);
         SEL_CH1: trunc_hit = above_width(i, W1);
         SEL_CH2: trunc_hit = above_width(i, W2);
         SEL_CH3: trunc_hit = above_width(i, W3);
         default: trunc_hit = 1'b0;
      endcase
      trunc_err_d = accept & trunc_hit;
   end

   always_ff @(posedge clock) begin
      if (reset) trunc_err_q <= 1'b0;
      else       trunc_err_q <= trunc_err_d;
   end

   assign trunc_err = trunc_err_q;

   demux_slot #(.WIDTH(W0)) u_slot0 (
      .clock(clock), .reset(reset), .load(load[0]), .d(i[W0-1:0]),
      .ready(o0_ready), .q(o0), .valid(o0_valid)
   );
   demux_slot #(.WIDTH(W1)) u_slot1 (
      .clock(clock), .reset(reset), .load(load[1]), .d(i[W1-1:0]),
      .ready(o1_ready), .q(o1), .valid(o1_valid)
   );
   demux_slot #(.WIDTH(W2)) u_slot2 (
      .clock(clock), .reset(reset), .load(load[2]), .d(i[W2-1:0]),
      .ready(o2_ready), .q(o2), .valid(o2_valid)
   );
   demux_slot #(.WIDTH(W3)) u_slot3 (
      .clock(clock), .reset(reset), .load(load[3]), .d(i[W3-1:0]),
      .ready(o3_ready), .q(o3), .valid(o3_valid)
   );

endmodule

`default_nettype wire

// File: tb/tb_demux_2_4.sv
// +------------------------------------------------------------------+
// | tb_demux_2_4: directed and randomized checks of demux_2_4         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_demux_2_4;

   localparam int WID [4] = '{32, 16, 32, 8};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  select = 2'd0;
   logic [31:0] i = '0;
   logic [31:0] o0;
   logic [15:0] o1;
   logic [31:0] o2;
   logic [7:0]  o3;
   logic        o0_valid, o1_valid, o2_valid, o3_valid;
   logic        o0_ready = 1'b0, o1_ready = 1'b0, o2_ready = 1'b0, o3_ready = 1'b0;
   logic        trunc_err;

   int errors = 0;
   int checks = 0;

   demux_2_4 dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .select(select), .i(i),
      .o0(o0), .o1(o1), .o2(o2), .o3(o3),
      .o0_valid(o0_valid), .o1_valid(o1_valid), .o2_valid(o2_valid), .o3_valid(o3_valid),
      .o0_ready(o0_ready), .o1_ready(o1_ready), .o2_ready(o2_ready), .o3_ready(o3_ready),
      .trunc_err(trunc_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] low_bits(input logic [31:0] v, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return v & m[31:0];
   endfunction

   task automatic idle_inputs();
      in_valid = 1'b0;
      {o0_ready, o1_ready, o2_ready, o3_ready} = 4'b0000;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({o0_valid, o1_valid, o2_valid, o3_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0000", {o0_valid, o1_valid, o2_valid, o3_valid});
      end
      checks++;
      if (o0 !== 32'h0 || o1 !== 16'h0 || o2 !== 32'h0 || o3 !== 8'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h %h want zeros", o0, o1, o2, o3);
      end
      checks++;
      if (trunc_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_trunc: got %b want 0", trunc_err);
      end
      for (int s = 0; s < 4; s++) begin
         select = 2'(s);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, in_ready);
         end
      end
   endtask

   task automatic test_narrow_write();
      select = 2'd1; i = 32'h0000_BEEF; in_valid = 1'b1; o1_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (o1 !== 16'hBEEF || o1_valid !== 1'b1) begin
         errors++;
         $display("FAIL narrow_ch1: got o1=%h v=%b want BEEF v=1", o1, o1_valid);
      end
      checks++;
      if (trunc_err !== 1'b0 || {o0_valid, o2_valid, o3_valid} !== 3'b000) begin
         errors++;
         $display("FAIL narrow_others: got trunc=%b v023=%b want 0 000", trunc_err,
                  {o0_valid, o2_valid, o3_valid});
      end
      tick();
      o1_ready = 1'b0;
      checks++;
      if (o1_valid !== 1'b0 || o1 !== 16'hBEEF) begin
         errors++;
         $display("FAIL narrow_drain: got o1=%h v=%b want BEEF v=0", o1, o1_valid);
      end
   endtask

   task automatic test_trunc();
      select = 2'd3; i = 32'h1234_56AB; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (o3 !== 8'hAB || o3_valid !== 1'b1 || trunc_err !== 1'b1) begin
         errors++;
         $display("FAIL trunc_ch3: got o3=%h v=%b te=%b want AB 1 1", o3, o3_valid, trunc_err);
      end
      tick();
      checks++;
      if (trunc_err !== 1'b0 || o3_valid !== 1'b1) begin
         errors++;
         $display("FAIL trunc_pulse: got te=%b v=%b want 0 1", trunc_err, o3_valid);
      end
      o3_ready = 1'b1;
      tick();
      o3_ready = 1'b0;
   endtask

   task automatic test_back_pressure();
      o0_ready = 1'b0;
      select = 2'd0; i = 32'hA5A5_0001; in_valid = 1'b1;
      tick();
      i = 32'h0000_0002;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_in_ready: got %b want 0", in_ready);
      end
      tick();
      checks++;
      if (o0 !== 32'hA5A5_0001 || o0_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold: got o0=%h v=%b want a5a50001 1", o0, o0_valid);
      end
      select = 2'd2; i = 32'h0000_0077;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_other_sel: got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (o2 !== 32'h77 || o2_valid !== 1'b1 || o0 !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL bp_ch2: got o2=%h v=%b o0=%h want 77 1 a5a50001", o2, o2_valid, o0);
      end
      o0_ready = 1'b1; o2_ready = 1'b1;
      tick();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      int seen;
      seen = 0;
      o2_ready = 1'b0;
      select = 2'd2; i = 32'h1; in_valid = 1'b1;
      tick();
      o2_ready = 1'b1; i = 32'h2;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_in_ready: got %b want 1", in_ready);
      end
      for (int c = 0; c < 3; c++) begin
         if (o2_valid && o2_ready) seen++;
         tick();
         in_valid = 1'b0;
         if (c == 0) begin
            checks++;
            if (o2 !== 32'h2 || o2_valid !== 1'b1) begin
               errors++;
               $display("FAIL b2b_refill: got o2=%h v=%b want 2 1", o2, o2_valid);
            end
         end
      end
      checks++;
      if (seen !== 2 || o2_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_count: got words=%0d v=%b want 2 0", seen, o2_valid);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; select = 2'd0; i = 32'hDEAD_0000;
      tick();
      select = 2'd3; i = 32'h0000_0042;
      tick();
      reset = 1'b1; select = 2'd1; i = 32'h0000_1111; o0_ready = 1'b1; o3_ready = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      checks++;
      if ({o0_valid, o1_valid, o2_valid, o3_valid} !== 4'b0000 ||
          o0 !== 32'h0 || o1 !== 16'h0 || o2 !== 32'h0 || o3 !== 8'h0 || trunc_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b o=%h %h %h %h te=%b want all zero",
                  {o0_valid, o1_valid, o2_valid, o3_valid}, o0, o1, o2, o3, trunc_err);
      end
      tick();
      checks++;
      if ({o0_valid, o1_valid, o2_valid, o3_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_after: got v=%b want 0000", {o0_valid, o1_valid, o2_valid, o3_valid});
      end
   endtask

   // Reference model: per-channel arrays updated from the channel rules each edge.
   task automatic test_random();
      logic        m_valid [4];
      logic [31:0] m_data  [4];
      logic        m_trunc;
      logic [3:0]  rdy;
      logic [31:0] got_data [4];
      logic [3:0]  got_valid;
      logic        exp_ready, acc;
      int          sel;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_valid[k] = 1'b0;
         m_data[k]  = '0;
      end
      m_trunc = 1'b0;
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(0, 59) == 0);
         in_valid = $urandom_range(0, 3) != 0;
         sel      = $urandom_range(0, 3);
         select   = 2'(sel);
         case ($urandom_range(0, 2))
            0:       i = $urandom_range(0, 255);
            1:       i = $urandom_range(0, 65535);
            default: i = $urandom;
         endcase
         rdy = 4'($urandom);
         {o3_ready, o2_ready, o1_ready, o0_ready} = rdy;
         #1;
         exp_ready = !m_valid[sel] || rdy[sel];
         checks++;
         if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL rnd_in_ready n=%0d: got %b want %b", n, in_ready, exp_ready);
         end
         acc = in_valid && exp_ready;
         if (reset) begin
            for (int k = 0; k < 4; k++) begin
               m_valid[k] = 1'b0;
               m_data[k]  = '0;
            end
            m_trunc = 1'b0;
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (acc && sel == k) begin
                  m_valid[k] = 1'b1;
                  m_data[k]  = low_bits(i, WID[k]);
               end else if (rdy[k]) begin
                  m_valid[k] = 1'b0;
               end
            end
            m_trunc = acc && (i != low_bits(i, WID[sel]));
         end
         tick();
         got_data  = '{o0, 32'(o1), o2, 32'(o3)};
         got_valid = {o3_valid, o2_valid, o1_valid, o0_valid};
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_valid[k] !== m_valid[k] || got_data[k] !== m_data[k]) begin
               errors++;
               $display("FAIL rnd_ch%0d n=%0d: got %h v=%b want %h v=%b", k, n,
                        got_data[k], got_valid[k], m_data[k], m_valid[k]);
            end
         end
         checks++;
         if (trunc_err !== m_trunc) begin
            errors++;
            $display("FAIL rnd_trunc n=%0d: got %b want %b", n, trunc_err, m_trunc);
         end
      end
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_narrow_write();
      test_trunc();
      test_back_pressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
